ldtu_ser_rx: RTL



---
 rtl/ldtu_rx_pkg.sv | 24 ++
 rtl/ldtu_rx_shifter.sv | 28 ++
 rtl/ldtu_ser_rx.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ldtu_rx_pkg.sv
// Shared types and constants for the LiTE DTU serial receiver.
package ldtu_rx_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } rx_state_e;

  localparam logic [31:0] IDLE_WORD_DEF = 32'hEAAA_AAAA;

  localparam logic [1:0] HDR_BASELINE = 2'b01;
  localparam logic [2:0] HDR_SIGNAL   = 3'b001;
  localparam logic [3:0] HDR_FRAME    = 4'b1101;

  // A word is legal if its header matches one of the known word types or it is the idle word.
  function automatic logic is_legal_word(input logic [31:0] word, input logic [31:0] idle);
    return (word[31:30] == HDR_BASELINE) ||
           (word[31:29] == HDR_SIGNAL)   ||
           (word[31:28] == HDR_FRAME)    ||
           (word == idle);
  endfunction

endpackage

// File: rtl/ldtu_rx_shifter.sv
// Serial-to-parallel shift register plus modulo-32 bit counter.
// sh_n is the value the register takes on the current edge; all word
// compares in the receiver look at it so decisions land on the LSB edge.
module ldtu_rx_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        ser_in,
  input  logic        cnt_clr,
  output logic [31:0] sh_n,
  output logic [4:0]  bit_cnt
);

  logic [31:0] sh;

  assign sh_n = {sh[30:0], ser_in};

  // Shift in one bit per edge; counter wraps at 32 and is cleared on an idle match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else begin
      sh      <= sh_n;
      bit_cnt <= cnt_clr ? 5'd0 : bit_cnt + 5'd1;
    end
  end

endmodule

// File: rtl/ldtu_ser_rx.sv
// Single-lane LiTE DTU serial receiver: word alignment on the idle word,
// legality check and strobed word output.
// Optional feature macro: LDTU_RX_ERRCNT_EN (8-bit saturating ERR_CNT).
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_HUNT   | bit-by-bit search for the idle word, no word boundary known
// ST_VERIFY | candidate boundary found, counting consecutive aligned idles
// ST_LOCKED | aligned; every word boundary produces exactly one strobe
module ldtu_ser_rx
  import ldtu_rx_pkg::*;
#(
  parameter logic [31:0] IDLE_WORD    = IDLE_WORD_DEF,
  parameter int          LOCK_COUNT   = 4,
  parameter int          UNLOCK_COUNT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SER_IN,
  output logic [31:0] DATA_OUT,
  output logic        DATA_VALID,
  output logic        IDLE_DET,
  output logic        WORD_ERR,
  output logic        LOCKED,
  output logic [7:0]  ERR_CNT
);

  localparam logic [3:0] LOCK_CNT4   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_CNT4 = 4'(UNLOCK_COUNT);

  logic [31:0] sh_n;
  logic [4:0]  bit_cnt;
  logic        cnt_clr;

  rx_state_e   state, state_nxt;
  logic [3:0]  good_cnt, good_nxt, good_inc;
  logic [3:0]  bad_cnt, bad_nxt, bad_inc;
  logic [31:0] data_nxt;
  logic        valid_nxt, idle_nxt, err_nxt;
  logic        word_end, is_idle, is_legal;

  ldtu_rx_shifter u_shifter (
    .clk     (CLK),
    .rst     (RST),
    .ser_in  (SER_IN),
    .cnt_clr (cnt_clr),
    .sh_n    (sh_n),
    .bit_cnt (bit_cnt)
  );

  assign word_end = (bit_cnt == 5'd31);
  assign is_idle  = (sh_n == IDLE_WORD);
  assign is_legal = is_legal_word(sh_n, IDLE_WORD);
  assign good_inc = good_cnt + 4'd1;
  assign bad_inc  = bad_cnt + 4'd1;

  // Next-state, counter and strobe decode.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    bad_nxt   = bad_cnt;
    cnt_clr   = 1'b0;
    data_nxt  = DATA_OUT;
    valid_nxt = 1'b0;
    idle_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_HUNT: begin
        if (is_idle) begin
          cnt_clr   = 1'b1;
          good_nxt  = 4'd1;
          bad_nxt   = 4'd0;
          state_nxt = (LOCK_CNT4 == 4'd1) ? ST_LOCKED : ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (word_end) begin
          if (is_idle) begin
            good_nxt = good_inc;
            if (good_inc == LOCK_CNT4) state_nxt = ST_LOCKED;
          end else begin
            good_nxt  = 4'd0;
            state_nxt = ST_HUNT;
          end
        end
      end
      ST_LOCKED: begin
        if (word_end) begin
          if (is_idle) begin
            idle_nxt = 1'b1;
            bad_nxt  = 4'd0;
          end else if (is_legal) begin
            data_nxt  = sh_n;
            valid_nxt = 1'b1;
            bad_nxt   = 4'd0;
          end else begin
            err_nxt = 1'b1;
            bad_nxt = bad_inc;
            if (bad_inc == UNLOCK_CNT4) state_nxt = ST_HUNT;
          end
        end
      end
      default: state_nxt = ST_HUNT;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_HUNT;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      IDLE_DET   <= 1'b0;
      WORD_ERR   <= 1'b0;
      LOCKED     <= 1'b0;
    end else begin
      state      <= state_nxt;
      good_cnt   <= good_nxt;
      bad_cnt    <= bad_nxt;
      DATA_OUT   <= data_nxt;
      DATA_VALID <= valid_nxt;
      IDLE_DET   <= idle_nxt;
      WORD_ERR   <= err_nxt;
      LOCKED     <= (state_nxt == ST_LOCKED);
    end
  end

`ifdef LDTU_RX_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of illegal words; survives loss of lock.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                             err_cnt_q <= '0;
    else if (err_nxt && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign ERR_CNT = err_cnt_q;
`else
  assign ERR_CNT = 8'd0;
`endif

endmodule
